// File: rtl/trade_multi.sv
// Multi-item vending trade controller: half-unit coin balance, priced item table,
// per-item stock counters, serial change return on cancel or inactivity timeout.
module trade_multi #(
    parameter int                    N_GOODS     = 12,
    parameter int                    IDX_W       = 4,
    parameter int                    MONEY_W     = 7,
    parameter int                    MONEY_MAX   = 99,
    parameter logic [4*N_GOODS-1:0]  PRICE_TABLE = 48'h153445332335,
    parameter int                    STOCK_W     = 3,
    parameter int                    STOCK_INIT  = 4,
    parameter int                    TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [1:0]         coin_type,
    input  logic [IDX_W-1:0]   goods_index,
    input  logic               buy_req,
    input  logic               cancel_req,
    input  logic               restock,
    output logic [MONEY_W-1:0] money,
    output logic               point_flag,
    output logic               enough_flag,
    output logic               sold_out,
    output logic               vend_valid,
    output logic [IDX_W-1:0]   vend_index,
    output logic               change_pulse,
    output logic               change_half,
    output logic               coin_reject,
    output logic               buy_reject,
    output logic               busy
);

    localparam int BAL_W  = MONEY_W + 1;
    localparam int BAL_W1 = BAL_W + 1;
    localparam int TIM_W  = $clog2(TIMEOUT_CYC);

    localparam logic [BAL_W1-1:0]  BAL_LIMIT = BAL_W1'(2 * MONEY_MAX);
    localparam logic [TIM_W-1:0]   TIM_LAST  = TIM_W'(TIMEOUT_CYC - 1);
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

    // Encoding puts VEND and REFUND in the upper half so busy is state[1].
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CREDIT = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_REFUND = 2'd3;

    logic [1:0]         state;
    logic [BAL_W-1:0]   bal;
    logic [TIM_W-1:0]   timer;
    logic [STOCK_W-1:0] stock [1:N_GOODS];

    logic               idx_valid;
    logic [3:0]         price_sel;
    logic [STOCK_W-1:0] stock_sel;
    logic [BAL_W-1:0]   price_half;
    logic [BAL_W-1:0]   coin_half;
    logic [BAL_W1-1:0]  coin_sum;
    logic               coin_ok;

    always_comb begin
        idx_valid = (goods_index != '0) && (goods_index <= IDX_W'(N_GOODS));
        price_sel = '0;
        stock_sel = '0;
        if (idx_valid) begin
            price_sel = PRICE_TABLE[4*int'(goods_index)-4 +: 4];
            stock_sel = stock[goods_index];
        end
        price_half = BAL_W'({price_sel, 1'b0});
        case (coin_type)
            2'b00:   coin_half = BAL_W'(1);
            2'b01:   coin_half = BAL_W'(2);
            2'b10:   coin_half = BAL_W'(10);
            default: coin_half = '0;
        endcase
        coin_sum = {1'b0, bal} + {1'b0, coin_half};
        coin_ok  = (coin_type != 2'b11) && (coin_sum <= BAL_LIMIT);
    end

    assign enough_flag = idx_valid && (bal >= price_half);
    assign sold_out    = idx_valid && (stock_sel == '0);
    assign money       = bal[MONEY_W:1];
    assign point_flag  = bal[0];
    assign busy        = state[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            bal          <= '0;
            timer        <= '0;
            vend_valid   <= 1'b0;
            vend_index   <= '0;
            change_pulse <= 1'b0;
            change_half  <= 1'b0;
            coin_reject  <= 1'b0;
            buy_reject   <= 1'b0;
            // NOTE: stock is a few small counters, not a RAM, so it is reset like any register.
            for (int i = 1; i <= N_GOODS; i++) stock[i] <= STOCK_RST;
        end else begin
            // NOTE: pulses default low here and are overridden below; last NBA wins.
            vend_valid   <= 1'b0;
            change_pulse <= 1'b0;
            change_half  <= 1'b0;
            coin_reject  <= 1'b0;
            buy_reject   <= 1'b0;
            timer        <= '0;
            case (state)
                S_IDLE: begin
                    if (restock)
                        for (int i = 1; i <= N_GOODS; i++) stock[i] <= STOCK_RST;
                    buy_reject <= buy_req;
                    if (coin_valid) begin
                        if (coin_ok) begin
                            bal   <= coin_sum[BAL_W-1:0];
                            state <= S_CREDIT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                S_CREDIT: begin
                    if (cancel_req) begin
                        state       <= S_REFUND;
                        coin_reject <= coin_valid;
                    end else if (buy_req) begin
                        coin_reject <= coin_valid;
                        if (enough_flag && !sold_out) begin
                            bal                <= bal - price_half;
                            stock[goods_index] <= stock_sel - 1'b1;
                            vend_valid         <= 1'b1;
                            vend_index         <= goods_index;
                            state              <= S_VEND;
                        end else begin
                            buy_reject <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (coin_ok) bal <= coin_sum[BAL_W-1:0];
                        else         coin_reject <= 1'b1;
                    end else if (timer == TIM_LAST) begin
                        state <= S_REFUND;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_VEND: begin
                    coin_reject <= coin_valid;
                    buy_reject  <= buy_req;
                    state       <= (bal != '0) ? S_CREDIT : S_IDLE;
                end
                default: begin  // S_REFUND: one coin of change per cycle
                    coin_reject <= coin_valid;
                    buy_reject  <= buy_req;
                    if (bal >= BAL_W'(2)) begin
                        change_pulse <= 1'b1;
                        bal          <= bal - BAL_W'(2);
                    end else if (bal == BAL_W'(1)) begin
                        change_half <= 1'b1;
                        bal         <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trade_multi.sv
// Self-checking bench for trade_multi: pulse outputs are matched against a
// scoreboard queue filled as stimulus is driven; levels are checked directly.
module tb_trade_multi;

    localparam int N_GOODS = 12;
    localparam int IDX_W   = 4;
    localparam int MONEY_W = 7;
    localparam int MONEY_MAX = 99;
    localparam int STOCK_INIT = 4;
    localparam int TIMEOUT = 1000;
    localparam logic [47:0] PRICES = 48'h153445332335;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               coin_valid = 1'b0;
    logic [1:0]         coin_type = 2'b00;
    logic [IDX_W-1:0]   goods_index = '0;
    logic               buy_req = 1'b0;
    logic               cancel_req = 1'b0;
    logic               restock = 1'b0;
    logic [MONEY_W-1:0] money;
    logic               point_flag, enough_flag, sold_out, vend_valid;
    logic [IDX_W-1:0]   vend_index;
    logic               change_pulse, change_half, coin_reject, buy_reject, busy;

    trade_multi #(
        .N_GOODS(N_GOODS), .IDX_W(IDX_W), .MONEY_W(MONEY_W), .MONEY_MAX(MONEY_MAX),
        .PRICE_TABLE(PRICES), .STOCK_W(3), .STOCK_INIT(STOCK_INIT), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
        .goods_index(goods_index), .buy_req(buy_req), .cancel_req(cancel_req),
        .restock(restock), .money(money), .point_flag(point_flag),
        .enough_flag(enough_flag), .sold_out(sold_out), .vend_valid(vend_valid),
        .vend_index(vend_index), .change_pulse(change_pulse), .change_half(change_half),
        .coin_reject(coin_reject), .buy_reject(buy_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_VEND, EV_CHANGE, EV_HALF, EV_COIN_REJ, EV_BUY_REJ} ev_kind_t;
    typedef struct packed { ev_kind_t kind; int idx; } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  exp_bal = 0;
    int  exp_stock [1:N_GOODS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int price(input int i);
        logic [47:0] t;
        t = PRICES;
        return int'(t[4*i-4 +: 4]);
    endfunction

    task automatic push_ev(input ev_kind_t k, input int idx);
        ev_t e;
        e.kind = k;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input ev_kind_t k, input int idx);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", k, 32'hFFFF);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            if (k == EV_VEND) check("vend_index", idx, e.idx);
        end
    endtask

    // Monitor: every pulse the DUT produces must be the next scoreboard entry.
    always @(negedge clk) begin
        if (vend_valid === 1'b1)   match_ev(EV_VEND, int'(vend_index));
        if (change_pulse === 1'b1) match_ev(EV_CHANGE, 0);
        if (change_half === 1'b1)  match_ev(EV_HALF, 0);
        if (coin_reject === 1'b1)  match_ev(EV_COIN_REJ, 0);
        if (buy_reject === 1'b1)   match_ev(EV_BUY_REJ, 0);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_reset();
        exp_bal = 0;
        for (int i = 1; i <= N_GOODS; i++) exp_stock[i] = STOCK_INIT;
    endtask

    task automatic coin(input logic [1:0] t);
        int v;
        v = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : (t == 2'b10) ? 10 : 0;
        if (t == 2'b11 || exp_bal + v > 2 * MONEY_MAX) push_ev(EV_COIN_REJ, 0);
        else exp_bal += v;
        coin_valid = 1'b1;
        coin_type  = t;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic buy(input int idx);
        bit ok;
        ok = 1'b0;
        if (idx >= 1 && idx <= N_GOODS)
            if (exp_bal >= 2 * price(idx) && exp_stock[idx] > 0) ok = 1'b1;
        if (ok) begin
            push_ev(EV_VEND, idx);
            exp_bal -= 2 * price(idx);
            exp_stock[idx]--;
        end else begin
            push_ev(EV_BUY_REJ, 0);
        end
        goods_index = IDX_W'(idx);
        buy_req = 1'b1;
        step();
        buy_req = 1'b0;
    endtask

    task automatic cancel_refund();
        int pulses, half;
        pulses = exp_bal / 2;
        half   = exp_bal % 2;
        for (int i = 0; i < pulses; i++) push_ev(EV_CHANGE, 0);
        if (half != 0) push_ev(EV_HALF, 0);
        cancel_req = 1'b1;
        step();
        cancel_req = 1'b0;
        check("refund_busy_start", busy, 1);
        for (int k = 1; k <= pulses + half; k++) begin
            step();
            check("refund_busy", busy, 1);
            check("refund_change_pulse", change_pulse, k <= pulses);
            check("refund_change_half", change_half, k > pulses);
        end
        step();
        check("refund_done_busy", busy, 0);
        check("refund_done_money", money, 0);
        check("refund_done_point", point_flag, 0);
        exp_bal = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        model_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("rst_money", money, 0);
        check("rst_point", point_flag, 0);
        check("rst_busy", busy, 0);
        check("rst_vend_valid", vend_valid, 0);
        check("rst_vend_index", vend_index, 0);
        check("rst_sold_out", sold_out, 0);
        check("rst_enough", enough_flag, 0);

        // 1: 3.5 units, buy item 2 (price 3), coin during VEND is refused
        coin(2'b01); coin(2'b01); coin(2'b01); coin(2'b00);
        check("t1_money", money, 3);
        check("t1_point", point_flag, 1);
        goods_index = 4'd2;
        #1 check("t1_enough", enough_flag, 1);
        buy(2);
        check("t1_vend_valid", vend_valid, 1);
        check("t1_vend_index", vend_index, 2);
        check("t1_money_after", money, 0);
        check("t1_point_after", point_flag, 1);
        check("t1_busy_vend", busy, 1);
        push_ev(EV_COIN_REJ, 0);
        coin_valid = 1'b1; coin_type = 2'b01;
        step();
        coin_valid = 1'b0;
        check("t1_busy_after_vend", busy, 0);
        check("t1_point_kept", point_flag, 1);

        // 2: 1 unit, item 1 too expensive, item 12 drains balance to IDLE
        coin(2'b00);
        check("t2_money", money, 1);
        goods_index = 4'd1;
        #1 check("t2_enough_low", enough_flag, 0);
        buy(1);
        idle(1);
        check("t2_money_kept", money, 1);
        buy(12);
        idle(1);
        check("t2_money_zero", money, 0);
        check("t2_point_zero", point_flag, 0);
        check("t2_idle_busy", busy, 0);
        cancel_req = 1'b1;
        step();
        cancel_req = 1'b0;
        check("t2_idle_cancel_busy", busy, 0);
        buy(12);
        idle(1);

        // 3: saturation at MONEY_MAX, no partial credit, reserved coin
        for (int i = 0; i < 19; i++) coin(2'b10);
        check("t3_money_95", money, 95);
        coin(2'b10);
        check("t3_money_still_95", money, 95);
        for (int i = 0; i < 4; i++) coin(2'b01);
        check("t3_money_99", money, 99);
        coin(2'b00);
        coin(2'b11);
        check("t3_money_capped", money, 99);
        check("t3_point_capped", point_flag, 0);
        cancel_refund();

        // 4: 7.5 units refunded as 7 whole pulses then one half
        coin(2'b10); coin(2'b01); coin(2'b01); coin(2'b00);
        check("t4_money", money, 7);
        check("t4_point", point_flag, 1);
        cancel_refund();

        // 5: stock exhaustion on item 4 (price 2), restock honoured only in IDLE
        coin(2'b10); coin(2'b10);
        for (int i = 0; i < 4; i++) begin
            buy(4);
            idle(1);
        end
        goods_index = 4'd4;
        #1 check("t5_sold_out", sold_out, 1);
        check("t5_enough", enough_flag, 1);
        buy(4);
        idle(1);
        restock = 1'b1;
        step();
        restock = 1'b0;
        check("t5_restock_ignored", sold_out, 1);
        cancel_refund();
        check("t5_sold_out_idle", sold_out, 1);
        restock = 1'b1;
        step();
        restock = 1'b0;
        for (int i = 1; i <= N_GOODS; i++) exp_stock[i] = STOCK_INIT;
        check("t5_restocked", sold_out, 0);

        // 6a: inactivity timeout
        coin(2'b01);
        push_ev(EV_CHANGE, 0);
        cnt = 0;
        while (busy !== 1'b1 && cnt < TIMEOUT + 10) begin
            step();
            cnt++;
        end
        check("t6_timeout_window", (cnt >= TIMEOUT - 1) && (cnt <= TIMEOUT + 1), 1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 5) begin
            step();
            cnt++;
        end
        check("t6_timeout_refund_done", busy, 0);
        check("t6_timeout_money", money, 0);
        exp_bal = 0;

        // 6b: buy and coin together -> buy wins, coin refused
        coin(2'b01); coin(2'b01);
        goods_index = 4'd12;
        push_ev(EV_VEND, 12);
        push_ev(EV_COIN_REJ, 0);
        exp_bal -= 2 * price(12);
        exp_stock[12]--;
        buy_req = 1'b1; coin_valid = 1'b1; coin_type = 2'b01;
        step();
        buy_req = 1'b0; coin_valid = 1'b0;
        idle(1);
        check("t6_money_after_buy", money, 1);

        // 6c: reset in the middle of a refund
        coin(2'b10);
        check("t6_money_6", money, 6);
        push_ev(EV_CHANGE, 0);
        cancel_req = 1'b1;
        step();
        cancel_req = 1'b0;
        step();
        check("t6_refund_running", busy, 1);
        rst = 1'b1;
        step();
        check("t6_rst_money", money, 0);
        check("t6_rst_point", point_flag, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_change", change_pulse, 0);
        check("t6_rst_half", change_half, 0);
        check("t6_rst_vend_valid", vend_valid, 0);
        check("t6_rst_vend_index", vend_index, 0);
        check("t6_rst_coin_rej", coin_reject, 0);
        check("t6_rst_buy_rej", buy_reject, 0);
        rst = 1'b0;
        model_reset();
        idle(3);
        check("t6_post_rst_busy", busy, 0);
        check("t6_post_rst_money", money, 0);

        check("leftover_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trade_multi.md
Name: trade_multi

Overview:
- Parametrised successor of the vending trade controller.
- Accepts half/one/five-unit coins into a saturating half-unit balance.
- Sells from a parameter price table with per-item stock counters.
- Returns change serially on cancel or inactivity timeout.
- Sits between the touch-area decoder (which produces the pulses below) and the display/dispense logic.

Parameters:
N_GOODS, 12, number of sellable items; indices 1..N_GOODS are valid.
IDX_W, 4, width of goods_index; must satisfy 2^IDX_W > N_GOODS.
MONEY_W, 7, width of whole-unit money output.
MONEY_MAX, 99, maximum whole-unit balance; must be less than 2^MONEY_W.
PRICE_TABLE, 48'h153445332335, 4 bits per item in whole units (1..15); item i occupies bits [4i-1:4i-4].
STOCK_W, 3, width of each stock counter.
STOCK_INIT, 4, stock loaded per item at reset and on restock.
TIMEOUT_CYC, 1000, inactivity cycles in CREDIT before auto-refund; minimum 2.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  reset, synchronous, active-high.
coin_valid  in  1  one-cycle coin-insert pulse.
coin_type  in  2  00=half unit, 01=one unit, 10=five units, 11=reserved.
goods_index  in  IDX_W  currently selected item, level input.
buy_req  in  1  one-cycle purchase pulse.
cancel_req  in  1  one-cycle cancel/refund pulse.
restock  in  1  reload all stock counters to STOCK_INIT; honoured only in IDLE.
money  out  MONEY_W  whole-unit part of balance.
point_flag  out  1  half-unit part of balance.
enough_flag  out  1  combinational: valid index AND balance >= 2*price.
sold_out  out  1  combinational: valid index AND stock == 0.
vend_valid  out  1  one-cycle dispense pulse.
vend_index  out  IDX_W  item dispensed; qualified by vend_valid.
change_pulse  out  1  one-cycle pulse per whole unit returned.
change_half  out  1  one-cycle pulse for the returned half unit.
coin_reject  out  1  one-cycle pulse; the coin was not credited.
buy_reject  out  1  one-cycle pulse; the purchase was refused.
busy  out  1  high in VEND or REFUND.

Behaviour:
- Internal balance bal is MONEY_W+1 bits in half units. money = bal[MONEY_W:1]; point_flag = bal[0].
- Reset (rst high at a clk edge):
  - bal = 0 and state = IDLE.
  - All stock counters = STOCK_INIT; inactivity timer = 0.
  - All pulse outputs = 0; vend_index = 0.
  - rst mid-REFUND abandons the remaining change.
- All outputs are registered except enough_flag and sold_out. Responses appear the cycle after the request edge.
- Coin value in half units: 1, 2 or 10.
  - Reserved coin type -> coin_reject.
  - If bal + value > 2*MONEY_MAX -> coin_reject, bal unchanged (no partial credit).
- States:
  - IDLE: bal == 0.
    - Accepted coin -> CREDIT.
    - buy_req -> buy_reject.
    - cancel_req ignored.
  - CREDIT:
    - Per-cycle priority: cancel_req > buy_req > coin_valid. A coin arriving with cancel or buy in the same cycle gets coin_reject.
    - cancel_req -> REFUND.
    - buy_req with enough_flag high and sold_out low -> VEND:
      - bal -= 2*price; selected stock -= 1.
      - vend_valid = 1 and vend_index = goods_index in the next cycle.
    - buy_req otherwise (invalid index, insufficient balance or sold out) -> buy_reject, stay in CREDIT.
    - Timer resets on any coin, buy or cancel pulse and increments otherwise. Reaching TIMEOUT_CYC-1 -> REFUND.
  - VEND: exactly one cycle.
    - Coins -> coin_reject; buy_req -> buy_reject; cancel_req ignored.
    - Next state is CREDIT if bal > 0, else IDLE.
  - REFUND: one action per cycle.
    - bal >= 2: change_pulse = 1, bal -= 2.
    - bal == 1: change_half = 1, bal = 0.
    - Move to IDLE in the cycle after bal reaches 0.
    - Coins -> coin_reject; buy_req -> buy_reject; cancel_req ignored.
- Stock never decrements below 0; sold_out blocks the buy.
- restock outside IDLE is ignored.
- Timer is held at 0 outside CREDIT.

Test Plan:
1. Reset, then coin 01 x3 and coin 00 x1 -> money=3, point_flag=1. Select index 2, buy -> vend_valid with vend_index=2; money=0, point_flag=1.
2. Balance 1 unit, index 1 (price 5), buy -> buy_reject; money stays 1; enough_flag=0. Set index 12, buy -> vend, balance 0, state IDLE.
3. Balance 95, coin 10 -> coin_reject, money stays 95. Coin 01 x4 -> money=99. Further coin 00 -> coin_reject.
4. Balance 7.5, cancel_req -> 7 change_pulse in consecutive cycles, then 1 change_half, busy high throughout, then IDLE with money=0.
5. Buy index 4 five times with sufficient balance -> 4 vends, 5th gives buy_reject with sold_out=1. Restock in IDLE -> sold_out=0.
6. Coin then no activity for TIMEOUT_CYC cycles -> auto-refund. Simultaneous buy_req and coin_valid -> buy processed, coin_reject. rst asserted mid-REFUND -> all outputs 0 next cycle.
